// File: rtl/failure_responder.sv
// failure_responder
//
// Watches the stop and unclocked-failure (ucf) levels coming from the
// emulation top. It records each armed rising edge of (stop | ucf) as an
// event {cause, timestamp} in a small FIFO that the host drains. The first
// event seen while running asks the emulator to halt its clocks. A
// resume pulse releases the halt after the emulator acknowledges it.
//
// Parameters
//   TS_W   width of the free-running timestamp counter and of evt_time
//   DEPTH  event FIFO entries (power of two, 2..16)
//
// Ports
//   clk        in   design clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   stop       in   stop-request level
//   ucf        in   unclocked-failure level
//   arm        in   event capture enable
//   failure    out  registered stop|ucf
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   host accepts the head event
//   evt_cause  out  head cause, bit1 = ucf, bit0 = stop
//   evt_time   out  head timestamp
//   drop_cnt   out  saturating count of events lost to a full FIFO
//   halt_req   out  clock-stop request to the emulator
//   halt_ack   in   emulator acknowledges the halt
//   resume     in   single-cycle pulse releasing the halt

module failure_responder #(
  parameter int TS_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stop,
  input  logic            ucf,
  input  logic            arm,
  output logic            failure,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_cause,
  output logic [TS_W-1:0] evt_time,
  output logic [7:0]      drop_cnt,
  output logic            halt_req,
  input  logic            halt_ack,
  input  logic            resume
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = TS_W + 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  logic [TS_W-1:0]  ts_q,        ts_d;
  logic             fail_prev_q, fail_prev_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W:0]   count_q,     count_d;
  logic [7:0]       drop_q,      drop_d;
  state_t           state_q,     state_d;

  logic             fail_now;
  logic             evt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [ENT_W-1:0] head;

  // Event detection. A level held high produces one event only, and an
  // unarmed edge is invisible to the FIFO, the drop counter and the FSM.
  assign fail_now   = stop | ucf;
  assign evt        = fail_now & ~fail_prev_q & arm;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign pop        = ~fifo_empty & evt_ready;

  // A full FIFO still accepts an event when the head leaves in the same
  // cycle, because the write lands in the slot being freed.
  assign push       = evt & (~fifo_full | pop);
  assign drop       = evt & fifo_full & ~pop;

  // The head is forced to zero while empty so stale entries never show.
  assign head       = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign failure    = fail_prev_q;
  assign evt_valid  = ~fifo_empty;
  assign evt_cause  = head[ENT_W-1 -: 2];
  assign evt_time   = head[TS_W-1:0];
  assign drop_cnt   = drop_q;
  assign halt_req   = (state_q == ST_HALT_REQ);

  // Timestamp counter, edge history and FIFO next-state.
  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    fail_prev_d = fail_now;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    drop_d      = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = {ucf, stop, ts_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Halt handshake. Only an event seen while running starts a halt.
  // Later events are still queued or counted but leave the state alone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (evt)      state_d = ST_HALT_REQ;
      ST_HALT_REQ: if (halt_ack) state_d = ST_HALTED;
      ST_HALTED:   if (resume)   state_d = ST_RUN;
      default:                   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      fail_prev_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      state_q     <= ST_RUN;
    end else begin
      ts_q        <= ts_d;
      fail_prev_q <= fail_prev_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_failure_responder.sv
// Bench for failure_responder. Two instances share every input: one with
// a 32-bit timestamp and one with a 4-bit timestamp, so counter wrap shows
// up naturally. A scoreboard queue gets the expected record whenever an
// event is driven. The head is compared while the DUT presents it, and
// the entry is popped when the host handshake completes.

module tb_failure_responder;

   localparam int DEPTH = 4;

   typedef enum int {M_RUN, M_HALT_REQ, M_HALTED} modelState_t;

   logic        clock = 1'b0;
   logic        rstN;
   logic        stopIn = 1'b0;
   logic        ucfIn = 1'b0;
   logic        armIn = 1'b1;
   logic        readyIn = 1'b0;
   logic        ackIn = 1'b0;
   logic        resumeIn = 1'b0;

   logic        failure, evtValid, haltReq;
   logic [1:0]  evtCause;
   logic [31:0] evtTime;
   logic [7:0]  dropCnt;

   logic        failureSmall, evtValidSmall, haltReqSmall;
   logic [1:0]  evtCauseSmall;
   logic [3:0]  evtTimeSmall;
   logic [7:0]  dropCntSmall;

   int          checkCount = 0;
   int          errorCount = 0;

   // Reference model state: expected {cause, time} records, bench-side
   // timestamp, edge history, drop counter and halt FSM.
   logic [33:0] scoreboard [$];
   logic [31:0] tbTs = '0;
   logic        failPrev = 1'b0;
   int          dropModel = 0;
   modelState_t fsmModel = M_RUN;

   failure_responder #(.TS_W(32), .DEPTH(DEPTH)) dut (
      .clk(clock), .rst_n(rstN), .stop(stopIn), .ucf(ucfIn), .arm(armIn),
      .failure(failure), .evt_valid(evtValid), .evt_ready(readyIn),
      .evt_cause(evtCause), .evt_time(evtTime), .drop_cnt(dropCnt),
      .halt_req(haltReq), .halt_ack(ackIn), .resume(resumeIn)
   );

   failure_responder #(.TS_W(4), .DEPTH(DEPTH)) dutSmall (
      .clk(clock), .rst_n(rstN), .stop(stopIn), .ucf(ucfIn), .arm(armIn),
      .failure(failureSmall), .evt_valid(evtValidSmall), .evt_ready(readyIn),
      .evt_cause(evtCauseSmall), .evt_time(evtTimeSmall), .drop_cnt(dropCntSmall),
      .halt_req(haltReqSmall), .halt_ack(ackIn), .resume(resumeIn)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle. Entered and left on a falling edge. First it compares
   // what the DUTs show now against the model. Then it advances the model
   // with the inputs held for this cycle and steps past the rising edge.
   task automatic applyStimulus();
      logic [33:0] head;
      logic        failNow;
      logic        ev;
      logic        pop;
      checkOutput("failure", failure, failPrev);
      checkOutput("failure4", failureSmall, failPrev);
      checkOutput("halt_req", haltReq, fsmModel == M_HALT_REQ);
      checkOutput("halt_req4", haltReqSmall, fsmModel == M_HALT_REQ);
      checkOutput("drop_cnt", dropCnt, dropModel);
      checkOutput("drop_cnt4", dropCntSmall, dropModel);
      checkOutput("evt_valid", evtValid, scoreboard.size() != 0);
      checkOutput("evt_valid4", evtValidSmall, scoreboard.size() != 0);
      if (scoreboard.size() != 0) begin
         head = scoreboard[0];
         checkOutput("evt_cause", evtCause, head[33:32]);
         checkOutput("evt_time", evtTime, head[31:0]);
         checkOutput("evt_cause4", evtCauseSmall, head[33:32]);
         checkOutput("evt_time4", evtTimeSmall, head[3:0]);
      end

      failNow = stopIn | ucfIn;
      ev      = failNow && !failPrev && armIn;
      pop     = (scoreboard.size() != 0) && readyIn;
      if (pop) void'(scoreboard.pop_front());
      if (ev) begin
         if (scoreboard.size() < DEPTH) scoreboard.push_back({ucfIn, stopIn, tbTs});
         else if (dropModel < 255) dropModel++;
      end
      case (fsmModel)
         M_RUN:      if (ev)       fsmModel = M_HALT_REQ;
         M_HALT_REQ: if (ackIn)    fsmModel = M_HALTED;
         M_HALTED:   if (resumeIn) fsmModel = M_RUN;
         default:                  fsmModel = M_RUN;
      endcase
      failPrev = failNow;

      @(posedge clock);
      tbTs++;
      @(negedge clock);
   endtask

   // Asserts reset away from any clock edge and checks the outputs clear
   // immediately. It then holds reset across a rising edge and releases it
   // on a falling edge with the model cleared.
   task automatic resetDut(input string tag);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput({tag, "_evt_valid"}, evtValid, 1'b0);
      checkOutput({tag, "_evt_cause"}, evtCause, 2'b00);
      checkOutput({tag, "_evt_time"}, evtTime, 32'd0);
      checkOutput({tag, "_drop_cnt"}, dropCnt, 8'd0);
      checkOutput({tag, "_halt_req"}, haltReq, 1'b0);
      checkOutput({tag, "_failure"}, failure, 1'b0);
      checkOutput({tag, "_evt_valid4"}, evtValidSmall, 1'b0);
      checkOutput({tag, "_halt_req4"}, haltReqSmall, 1'b0);
      @(negedge clock);
      @(negedge clock);
      rstN = 1'b1;
      scoreboard.delete();
      tbTs      = '0;
      failPrev  = 1'b0;
      dropModel = 0;
      fsmModel  = M_RUN;
   endtask

   // Single-cycle pulse on stop to create one clean rising edge.
   task automatic stopEdge();
      stopIn = 1'b1;
      applyStimulus();
      stopIn = 1'b0;
      applyStimulus();
   endtask

   // Lets the host drain the FIFO for a bounded number of cycles.
   task automatic drain();
      readyIn = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus();
      readyIn = 1'b0;
   endtask

   // Main test sequence.
   initial begin
      @(negedge clock);
      resetDut("reset");

      // A stop rise at ts=10, held for five cycles, gives one event. The
      // halt request follows on the next cycle.
      for (int i = 0; i < 40 && tbTs != 10; i++) applyStimulus();
      stopIn = 1'b1;
      applyStimulus();
      checkOutput("first_evt_time", evtTime, 32'd10);
      checkOutput("first_halt_req", haltReq, 1'b1);
      repeat (4) applyStimulus();
      stopIn = 1'b0;
      applyStimulus();
      drain();

      // Halt handshake. An early resume is ignored, the ack moves to
      // HALTED, and resume returns to RUN.
      resumeIn = 1'b1; applyStimulus(); resumeIn = 1'b0;
      ackIn = 1'b1;    applyStimulus(); ackIn = 1'b0;
      applyStimulus();
      resumeIn = 1'b1; applyStimulus(); resumeIn = 1'b0;
      applyStimulus();

      // Simultaneous stop+ucf rise gives cause 11. A ucf rise while stop
      // is already high gives no event. Unarmed edges are ignored.
      stopIn = 1'b1; ucfIn = 1'b1; applyStimulus();
      applyStimulus();
      stopIn = 1'b0; applyStimulus();
      ucfIn = 1'b0;  applyStimulus();
      stopIn = 1'b1; applyStimulus();
      ucfIn = 1'b1;  applyStimulus();
      stopIn = 1'b0; ucfIn = 1'b0; applyStimulus();
      armIn = 1'b0;
      stopEdge();
      armIn = 1'b1;
      drain();

      // Six edges into a four-deep FIFO with no reads: two drops. Then an
      // edge that coincides with a pop is accepted.
      for (int i = 0; i < 6; i++) stopEdge();
      checkOutput("drop_after_six", dropCnt, 8'd2);
      readyIn = 1'b1; stopIn = 1'b1; applyStimulus();
      readyIn = 1'b0; stopIn = 1'b0; applyStimulus();
      checkOutput("drop_after_pop_push", dropCnt, 8'd2);
      drain();

      // Wrap of the 4-bit counter. Events land at 15, then at 1 after wrap.
      for (int i = 0; i < 40 && tbTs[3:0] != 4'd15; i++) applyStimulus();
      stopEdge();
      stopEdge();
      drain();

      // Mid-operation reset with three queued events and a pending halt.
      for (int i = 0; i < 3; i++) stopEdge();
      checkOutput("pre_reset_halt_req", haltReq, 1'b1);
      checkOutput("pre_reset_evt_valid", evtValid, 1'b1);
      stopIn = 1'b1;
      resetDut("mid_reset");

      // stop already high at release counts as a rising edge at ts 0.
      applyStimulus();
      stopIn = 1'b0;
      applyStimulus();
      drain();

      // Drop counter saturation.
      for (int i = 0; i < 262; i++) stopEdge();
      checkOutput("drop_saturated", dropCnt, 8'd255);
      drain();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
